// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-organised on-chip memory.
// Supports byte, halfword and word transfers with little-endian lane
// selection, a configurable number of wait states per OKAY data phase,
// and fully pipelined back-to-back address phases.
// Optional feature macro: AHB_SLAVE_MEM_ERR_EN
//   defined   -> out-of-range, oversized and misaligned transfers receive
//                the two-cycle ERROR response and never touch memory.
//   undefined -> every transfer completes OKAY; out-of-range writes are
//                dropped, out-of-range reads return zero and misaligned
//                accesses use the natural lanes of Haddr[1:0].
module ahb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

`ifdef AHB_SLAVE_MEM_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic             accept;
    logic             take_phase;
    logic             data_oor;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_en;
    logic             mem_we;
    logic             unused_htrans;

    assign accept        = Hsel & Hready & Htrans[1];
    assign data_oor      = (addr_q[ADDR_WIDTH-1:2] >= DEPTH_W);
    assign word_idx      = addr_q[2 +: IDX_W];
    assign mem_we        = (state_q == ST_DATA) & write_q & ~data_oor;
    assign unused_htrans = Htrans[0];

`ifdef AHB_SLAVE_MEM_ERR_EN
    logic req_bad;

    // Classify the address phase currently on the bus as a transfer to reject.
    always_comb begin
        req_bad = 1'b0;
        if (Haddr[ADDR_WIDTH-1:2] >= DEPTH_W) req_bad = 1'b1;
        if (Hsize > 3'b010) req_bad = 1'b1;
        if ((Hsize == 3'b001) && Haddr[0]) req_bad = 1'b1;
        if ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00)) req_bad = 1'b1;
    end
`endif

    // Next-state, pipelined address capture and bus response for each state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        take_phase = 1'b0;
        Hreadyout  = 1'b1;
        Hresp      = 2'b00;
        case (state_q)
            ST_IDLE: begin
                take_phase = 1'b1;
            end
            ST_WAIT: begin
                Hreadyout = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DATA;
            end
            ST_DATA: begin
                take_phase = 1'b1;
            end
`ifdef AHB_SLAVE_MEM_ERR_EN
            ST_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp      = 2'b01;
                take_phase = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (take_phase) begin
            if (accept) begin
                addr_d  = Haddr;
                write_d = Hwrite;
                size_d  = Hsize;
`ifdef AHB_SLAVE_MEM_ERR_EN
                if (req_bad) begin
                    state_d = ST_ERR1;
                end else
`endif
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, wait counter and registered address-phase controls.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Byte lanes touched by the registered transfer; halfwords pick the pair from Haddr[1].
    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            3'b000:  lane_en = 4'b0001 << addr_q[1:0];
            3'b001:  lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Storage update on the completing write data phase; memory is never reset.
    always_ff @(posedge Hclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem_q[word_idx][8*b +: 8] <= Hwdata[8*b +: 8];
            end
        end
    end

    // Read data is driven only while a read data phase completes, else zero.
    always_comb begin
        Hrdata = '0;
        if ((state_q == ST_DATA) && !write_q && !data_oor) Hrdata = mem_q[word_idx];
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem.
// Two instances (zero and three wait states) share a clock; a driver issues
// pipelined transfer sequences and queues the expected response from a
// byte-level memory model, while a monitor pops and checks each data phase.
module tb_ahb_slave_mem;

   localparam int DEPTH = 64;
   localparam int WS0   = 0;
   localparam int WS1   = 3;

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      bit          isWrite;
      bit          err;
      logic [31:0] data;
      int          cycles;
   } exp_t;

   logic        clk;
   logic        hreset    [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic [31:0] hrdata    [2];
   logic [1:0]  hresp     [2];
   logic        hreadyout [2];

   logic [31:0] refMem [2][DEPTH];
   exp_t        expQ0[$];
   exp_t        expQ1[$];
   xfer_t       seqQ[$];

   int  checks   = 0;
   int  failures = 0;
   bit  active   [2];
   int  cycles   [2];

   ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
      .Hclk(clk), .Hreset(hreset[0]), .Hsel(hsel[0]), .Haddr(haddr[0]), .Htrans(htrans[0]),
      .Hwrite(hwrite[0]), .Hsize(hsize[0]), .Hwdata(hwdata[0]), .Hready(hreadyout[0]),
      .Hrdata(hrdata[0]), .Hresp(hresp[0]), .Hreadyout(hreadyout[0])
   );

   ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
      .Hclk(clk), .Hreset(hreset[1]), .Hsel(hsel[1]), .Haddr(haddr[1]), .Htrans(htrans[1]),
      .Hwrite(hwrite[1]), .Hsize(hsize[1]), .Hwdata(hwdata[1]), .Hready(hreadyout[1]),
      .Hrdata(hrdata[1]), .Hresp(hresp[1]), .Hreadyout(hreadyout[1])
   );

   // Free-running bus clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the whole run wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic void checkOutput(input string name, input int inst,
                                       input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s inst%0d got=%h expected=%h at %0t", name, inst, act, expv, $time);
      end
   endfunction

   function automatic int wsOf(input int inst);
      return (inst == 0) ? WS0 : WS1;
   endfunction

   function automatic void pushExp(input int inst, input exp_t e);
      if (inst == 0) expQ0.push_back(e);
      else expQ1.push_back(e);
   endfunction

   function automatic int queueSize(input int inst);
      return (inst == 0) ? expQ0.size() : expQ1.size();
   endfunction

   function automatic exp_t queueFront(input int inst);
      return (inst == 0) ? expQ0[0] : expQ1[0];
   endfunction

   function automatic void queuePop(input int inst);
      if (inst == 0) void'(expQ0.pop_front());
      else void'(expQ1.pop_front());
   endfunction

   function automatic void queueClear(input int inst);
      if (inst == 0) expQ0.delete();
      else expQ1.delete();
   endfunction

   // Reference model: decide the response of one transfer and apply its write.
   function automatic exp_t computeExp(input int inst, input xfer_t x);
      exp_t        e;
      bit          inRange;
      bit          bad;
      int          word;
      int          first;
      int          count;
      word    = int'(x.addr >> 2);
      inRange = (x.addr >> 2) < DEPTH;
      bad     = 1'b0;
`ifdef AHB_SLAVE_MEM_ERR_EN
      bad = !inRange || (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
            (x.size == 3'd2 && x.addr[1:0] != 2'b00);
`endif
      e.isWrite = x.isWrite;
      e.err     = bad;
      e.data    = 32'h0;
      e.cycles  = bad ? 2 : wsOf(inst) + 1;
      if (!bad && inRange) begin
         if (x.isWrite) begin
            case (x.size)
               3'd0:    begin first = int'(x.addr & 32'd3); count = 1; end
               3'd1:    begin first = int'(x.addr & 32'd2); count = 2; end
               default: begin first = 0; count = 4; end
            endcase
            for (int b = first; b < first + count; b++)
               refMem[inst][word][8*b +: 8] = x.wdata[8*b +: 8];
         end else begin
            e.data = refMem[inst][word];
         end
      end
      return e;
   endfunction

   function automatic xfer_t mkXfer(input bit w, input logic [31:0] a, input logic [2:0] s,
                                    input logic [31:0] d);
      xfer_t x;
      x.isWrite = w;
      x.addr    = a;
      x.size    = s;
      x.wdata   = d;
      return x;
   endfunction

   function automatic xfer_t randXfer();
      xfer_t x;
      int    r;
      r         = $urandom_range(0, 99);
      x.isWrite = 1'($urandom_range(0, 1));
      x.size    = 3'($urandom_range(0, 2));
      x.wdata   = $urandom;
      x.addr    = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (x.size == 3'd0) x.addr = x.addr | 32'($urandom_range(0, 3));
      if (x.size == 3'd1) x.addr = x.addr | (32'($urandom_range(0, 1)) << 1);
      if (r < 6) x.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      else if (r < 9) x.addr = $urandom | 32'h8000_0000;
      else if (r < 15) x.addr = x.addr | 32'($urandom_range(1, 3));
`ifdef AHB_SLAVE_MEM_ERR_EN
      else if (r < 20) x.size = 3'($urandom_range(3, 7));
`endif
      return x;
   endfunction

   // Wait (bounded) until the slave is ready in the current cycle.
   task automatic waitReady(input int inst);
      int guard;
      guard = 0;
      while (!hreadyout[inst] && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!hreadyout[inst]) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout inst%0d got=0 expected=1", inst);
      end
   endtask

   // Drive seqQ back to back: each address phase overlaps the previous data phase.
   task automatic applyStimulus(input int inst);
      int n;
      n = seqQ.size();
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            hsel[inst]   = 1'b1;
            htrans[inst] = (k == 0) ? 2'b10 : 2'($urandom_range(2, 3));
            haddr[inst]  = seqQ[k].addr;
            hwrite[inst] = seqQ[k].isWrite;
            hsize[inst]  = seqQ[k].size;
            pushExp(inst, computeExp(inst, seqQ[k]));
         end else begin
            hsel[inst]   = 1'b0;
            htrans[inst] = 2'b00;
         end
         if (k > 0) hwdata[inst] = seqQ[k-1].wdata;
         waitReady(inst);
         @(posedge clk); #1;
      end
      seqQ.delete();
   endtask

   // Bus activity that must not start a data phase.
   task automatic idleCycles(input int inst, input int n);
      for (int c = 0; c < n; c++) begin
         hsel[inst]   = 1'($urandom_range(0, 1));
         htrans[inst] = hsel[inst] ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
         haddr[inst]  = $urandom;
         hwrite[inst] = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      hsel[inst]   = 1'b0;
      htrans[inst] = 2'b00;
   endtask

   task automatic checkResetOutputs(input int inst);
      checkOutput("rst_readyout", inst, 32'(hreadyout[inst]), 32'd1);
      checkOutput("rst_resp", inst, 32'(hresp[inst]), 32'd0);
      checkOutput("rst_rdata", inst, hrdata[inst], 32'd0);
   endtask

   task automatic directedTests(input int inst);
      seqQ.push_back(mkXfer(1, 32'h10, 3'd2, 32'hCAFE_F00D));
      seqQ.push_back(mkXfer(0, 32'h10, 3'd2, 32'h0));
      applyStimulus(inst);
      seqQ.push_back(mkXfer(1, 32'h10, 3'd2, 32'h1122_3344));
      seqQ.push_back(mkXfer(1, 32'h13, 3'd0, 32'hABAB_ABAB));
      seqQ.push_back(mkXfer(0, 32'h10, 3'd2, 32'h0));
      applyStimulus(inst);
      seqQ.push_back(mkXfer(0, 32'h14, 3'd2, 32'h0));
      applyStimulus(inst);
`ifdef AHB_SLAVE_MEM_ERR_EN
      seqQ.push_back(mkXfer(0, 32'(DEPTH * 4), 3'd2, 32'h0));
      seqQ.push_back(mkXfer(0, 32'h10, 3'd2, 32'h0));
      applyStimulus(inst);
      seqQ.push_back(mkXfer(1, 32'(DEPTH * 4), 3'd2, 32'h5555_AAAA));
      seqQ.push_back(mkXfer(1, 32'h02, 3'd2, 32'h7777_8888));
      seqQ.push_back(mkXfer(0, 32'h00, 3'd2, 32'h0));
      applyStimulus(inst);
`else
      seqQ.push_back(mkXfer(1, 32'h01, 3'd1, 32'h5A5A_A5A5));
      seqQ.push_back(mkXfer(0, 32'h00, 3'd2, 32'h0));
      applyStimulus(inst);
      seqQ.push_back(mkXfer(1, 32'(DEPTH * 4), 3'd2, 32'h5555_AAAA));
      seqQ.push_back(mkXfer(0, 32'(DEPTH * 4), 3'd2, 32'h0));
      seqQ.push_back(mkXfer(0, 32'h00, 3'd2, 32'h0));
      applyStimulus(inst);
`endif
   endtask

   // Monitor: every negedge, score the data phase in progress on each instance.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (hreset[i]) begin
            active[i] = 1'b0;
            queueClear(i);
         end else begin
            if (active[i]) begin
               if (queueSize(i) == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_data_phase inst%0d got=1 expected=0", i);
                  active[i] = 1'b0;
               end else begin
                  exp_t e;
                  e = queueFront(i);
                  cycles[i]++;
                  checkOutput("resp", i, 32'(hresp[i]), e.err ? 32'd1 : 32'd0);
                  if (hreadyout[i]) begin
                     checkOutput("latency", i, 32'(cycles[i]), 32'(e.cycles));
                     if (e.err) checkOutput("err_rdata", i, hrdata[i], 32'd0);
                     else if (!e.isWrite) checkOutput("rdata", i, hrdata[i], e.data);
                     queuePop(i);
                     active[i] = 1'b0;
                  end else begin
                     checkOutput("wait_rdata", i, hrdata[i], 32'd0);
                     if (cycles[i] > 40) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL data_timeout inst%0d got=%0d expected<=%0d",
                                 i, cycles[i], e.cycles);
                        queuePop(i);
                        active[i] = 1'b0;
                     end
                  end
               end
            end else begin
               checkOutput("idle_readyout", i, 32'(hreadyout[i]), 32'd1);
               checkOutput("idle_resp", i, 32'(hresp[i]), 32'd0);
               checkOutput("idle_rdata", i, hrdata[i], 32'd0);
            end
            if (!active[i] && hreadyout[i] && hsel[i] && htrans[i][1]) begin
               active[i] = 1'b1;
               cycles[i] = 0;
            end
         end
      end
   end

   // Main sequence: reset, fill memory, directed cases, random traffic, reset abort.
   initial begin
      for (int i = 0; i < 2; i++) begin
         hreset[i] = 1'b1;
         hsel[i]   = 1'b0;
         htrans[i] = 2'b00;
         haddr[i]  = 32'h0;
         hwrite[i] = 1'b0;
         hsize[i]  = 3'd0;
         hwdata[i] = 32'h0;
         active[i] = 1'b0;
         cycles[i] = 0;
      end
      #2;
      checkResetOutputs(0);
      checkResetOutputs(1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      hreset[0] = 1'b0;
      hreset[1] = 1'b0;

      for (int inst = 0; inst < 2; inst++) begin
         for (int w = 0; w < DEPTH; w++)
            seqQ.push_back(mkXfer(1, 32'(w * 4), 3'd2, 32'h0));
         applyStimulus(inst);
         if (inst == 1) begin
            seqQ.push_back(mkXfer(0, 32'h10, 3'd2, 32'h0));
            applyStimulus(inst);
         end
         directedTests(inst);
         for (int s = 0; s < 40; s++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) seqQ.push_back(randXfer());
            applyStimulus(inst);
            idleCycles(inst, $urandom_range(0, 3));
         end
      end

      seqQ.push_back(mkXfer(1, 32'h20, 3'd2, 32'h0));
      applyStimulus(1);
      begin
         exp_t e;
         e.isWrite = 1'b1;
         e.err     = 1'b0;
         e.data    = 32'h0;
         e.cycles  = WS1 + 1;
         hsel[1]   = 1'b1;
         htrans[1] = 2'b10;
         haddr[1]  = 32'h20;
         hwrite[1] = 1'b1;
         hsize[1]  = 3'd2;
         pushExp(1, e);
         waitReady(1);
         @(posedge clk); #1;
         hsel[1]   = 1'b0;
         htrans[1] = 2'b00;
         hwdata[1] = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         hreset[1] = 1'b1;
         #1;
         checkResetOutputs(1);
         @(posedge clk); #1;
         hreset[1] = 1'b0;
         @(posedge clk); #1;
      end
      seqQ.push_back(mkXfer(0, 32'h20, 3'd2, 32'h0));
      applyStimulus(1);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("drain", 0, 32'(queueSize(0)), 32'd0);
      checkOutput("drain", 1, 32'(queueSize(1)), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
